dot_product_stream: RTL and testbench
=====================================

// Module: dot_product_stream
// PURPOSE
//  Parametrised streaming dot-product engine: LANES pixel*weight products per beat, BEATS beats per vector
//  (default 28x28 = 784 terms). Classifier neurons consume one result per vector. Successor to the fixed
//  784-term engine; adds valid/ready flow control, bias, ReLU, saturation flag and abort.
// PARAMETERS
//  LANES     28  products per beat
//  BEATS     28  beats per vector (vector length = LANES*BEATS)
//  PIX_W     10  unsigned integer pixel width
//  WGT_W     19  signed weight width, two's complement
//  WGT_FRAC  16  weight fraction bits (1.0 = 1<<16)
//  OUT_W     26  signed result width
//  OUT_FRAC  16  result fraction bits; must be <= WGT_FRAC
//  localparam ACC_W = PIX_W+WGT_W+clog2(LANES*BEATS) (39 by default)
// PORTS
//  clk          in   1              rising-edge clock
//  GlobalReset  in   1              asynchronous, active-high reset
//  in_pixels    in   LANES*PIX_W    lane k at [k*PIX_W +: PIX_W]
//  in_weights   in   LANES*WGT_W    lane k at [k*WGT_W +: WGT_W]
//  in_valid     in   1              beat present
//  in_ready     out  1              beat accepted when in_valid&in_ready
//  bias         in   ACC_W          signed, WGT_FRAC fraction bits; sampled on first beat of a vector
//  relu_en      in   1              sampled on first beat of a vector
//  abort        in   1              sync flush of the vector in progress
//  out_value    out  OUT_W          signed result
//  out_sat      out  1              out_value was clipped
//  out_valid    out  1              result held until out_valid&out_ready
//  out_ready    in   1              consumer accepts
// BEHAVIOUR
//  - Reset: beat_cnt=0, all pipeline valid tags 0, out_value=0, out_sat=0, out_valid=0; in_ready=1 after reset.
//  - stall = out_valid & ~out_ready. in_ready = ~stall & ~abort (combinational). While stall is high, every
//    pipeline stage holds its value. No beat is dropped or duplicated.
//  - beat_cnt counts accepted beats 0..BEATS-1 and wraps to 0. Tag first=(cnt==0), last=(cnt==BEATS-1).
//  - S1: register LANES signed products (pixel zero-extended) with tags.
//  - S2: dp_adder_tree sum, registered, sign-extended to ACC_W.
//  - S3: accumulator. On a first beat: acc = bias + sum, latch relu_en. Otherwise: acc += sum.
//  - S4: on a last beat leaving S3: v = relu ? max(acc,0) : acc; v >>>= (WGT_FRAC-OUT_FRAC), truncating toward
//    -inf. Clip to signed OUT_W range; out_sat=1 iff clipped. Set out_valid=1.
//  - Latency: last beat accepted in cycle t -> out_valid in cycle t+4, when there is no stall.
//    Back-to-back vectors run with zero bubbles.
//  - out_valid clears on out_ready unless a new result loads the same cycle (that load takes priority).
//  - abort: beat_cnt=0 and S1..S3 tags cleared the next cycle, so the partial vector is discarded.
//    in_valid is ignored during abort. A result already in S4/out regs is kept.
//  - BEATS=1: every beat is both first and last.
//  - Reset mid-vector: all state is discarded and no result is produced.
// STRUCTURE
//  - Package dp_pkg: clog2 function, ACC_W derivation, sat_signed(value, width) function, default format constants.
//  - Sub-module dp_adder_tree (#LANES, IN_W): combinational balanced signed adder tree, output width IN_W+clog2(LANES).
//  - Top: beat counter, tag pipeline, accumulator, formatter/output register.
// TESTING
//  1) Weights all 0x10000 (1.0), pixel[i]=i%2 over 784 terms, out_ready=1, bias=0
//     -> out_value=0x1880000 (392.0), out_sat=0, out_valid 4 cycles after the last beat.
//  2) Same vector with bias=5<<16 -> 0x18D0000 (397.0).
//  3) Pixels 1023, weights 0x3FFFF -> out_value=0x1FFFFFF, out_sat=1. Weights 0x70000 (-1.0), pixels 1
//     -> 0x2000000, out_sat=1. Repeat with relu_en=1 -> 0, out_sat=0.
//  4) Two vectors back-to-back with out_ready=0 for 6 cycles around the first result -> in_ready low while
//     stalled; both results correct and in order (392.0, then 784 ones*1.0 saturates -> 0x1FFFFFF).
//  5) abort at beat 10 of vector A, then full vector B (test-1 data) -> exactly one result, 0x1880000.
//  6) GlobalReset pulse mid-vector (asynchronous, between clock edges) -> outputs 0 immediately,
//     in_ready=1 after release; the next full vector gives the correct result.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared format defaults and helpers for the streaming dot-product engine.
// Pure package: no logic, no latency, no flow control.
package dp_pkg;

    localparam int DEF_LANES    = 28;
    localparam int DEF_BEATS    = 28;
    localparam int DEF_PIX_W    = 10;
    localparam int DEF_WGT_W    = 19;
    localparam int DEF_WGT_FRAC = 16;
    localparam int DEF_OUT_W    = 26;
    localparam int DEF_OUT_FRAC = 16;

    // Widest value the saturation helper can handle.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic first;
        logic last;
    } beat_tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int pix_w, input int wgt_w, input int terms);
        return pix_w + wgt_w + clog2(terms);
    endfunction

    // Clip a signed value into the signed range of 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                            input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        r  = value;
        if (value > hi) r = hi;
        else if (value < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// Balanced signed pairwise adder tree over LANES packed inputs; purely combinational, no latency.
// No flow control: the caller registers around it.
module dp_adder_tree
    import dp_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IN_W  = 30
) (
    input  logic [LANES*IN_W-1:0]              in_i,
    output logic signed [IN_W+clog2(LANES)-1:0] sum_o
);

    localparam int LV    = clog2(LANES);
    localparam int SUM_W = IN_W + LV;
    localparam int NODES = 2 * LANES;

    // Nodes past the live count of a level stay zero, so odd levels pad naturally.
    logic signed [SUM_W-1:0] node [LV+1][NODES];

    always_comb begin
        for (int l = 0; l <= LV; l++) begin
            for (int i = 0; i < NODES; i++) node[l][i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            node[0][i] = SUM_W'($signed(in_i[i*IN_W +: IN_W]));
        end
        for (int l = 1; l <= LV; l++) begin
            for (int i = 0; i < LANES; i++) begin
                node[l][i] = node[l-1][2*i] + node[l-1][2*i+1];
            end
        end
    end

    assign sum_o = node[LV][0];

endmodule

// File: rtl/dot_product_stream.sv
// Streaming LANES x BEATS dot product with bias, ReLU and saturation; last beat to out_valid in 4 cycles.
// A held result (out_valid & ~out_ready) freezes every stage and drops in_ready; abort flushes the partial vector.
module dot_product_stream
    import dp_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int BEATS    = DEF_BEATS,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int WGT_W    = DEF_WGT_W,
    parameter int WGT_FRAC = DEF_WGT_FRAC,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int OUT_FRAC = DEF_OUT_FRAC
) (
    input  logic                                                    clk,
    input  logic                                                    GlobalReset,
    input  logic [LANES*PIX_W-1:0]                                  in_pixels,
    input  logic [LANES*WGT_W-1:0]                                  in_weights,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic signed [acc_width(PIX_W, WGT_W, LANES*BEATS)-1:0]  bias,
    input  logic                                                    relu_en,
    input  logic                                                    abort,
    output logic signed [OUT_W-1:0]                                 out_value,
    output logic                                                    out_sat,
    output logic                                                    out_valid,
    input  logic                                                    out_ready
);

    localparam int ACC_W  = acc_width(PIX_W, WGT_W, LANES * BEATS);
    localparam int CNT_W  = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int TREE_W = PROD_W + clog2(LANES);
    localparam int SHIFT  = WGT_FRAC - OUT_FRAC;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic                     stall;
    logic                     accept;
    logic                     load;

    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic                     s1_vld_q, s1_vld_d;
    logic                     s2_vld_q, s2_vld_d;
    logic                     s3_vld_q, s3_vld_d;

    logic [LANES*PROD_W-1:0]  prod_d, s1_prod_q;
    beat_tag_t                s1_tag_q, s2_tag_q;
    logic                     s1_relu_q, s2_relu_q, s3_relu_q;
    logic signed [ACC_W-1:0]  s1_bias_q, s2_bias_q;
    logic signed [TREE_W-1:0] tree_sum;
    logic signed [ACC_W-1:0]  s2_sum_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     s3_last_q;

    logic signed [ACC_W-1:0]  relu_val;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [SAT_W-1:0]  wide_val;
    logic signed [SAT_W-1:0]  clipped;

    logic signed [OUT_W-1:0]  out_value_q, out_value_d;
    logic                     out_sat_q, out_sat_d;
    logic                     out_valid_q, out_valid_d;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall & ~abort;
    assign accept   = in_valid & in_ready;

    // Pixels are unsigned, so they enter the multiplier with a zero sign bit.
    always_comb begin
        prod_d = '0;
        for (int k = 0; k < LANES; k++) begin
            prod_d[k*PROD_W +: PROD_W] = PROD_W'($signed({1'b0, in_pixels[k*PIX_W +: PIX_W]}))
                                       * PROD_W'($signed(in_weights[k*WGT_W +: WGT_W]));
        end
    end

    dp_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .in_i  (s1_prod_q),
        .sum_o (tree_sum)
    );

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        s1_vld_d   = s1_vld_q;
        s2_vld_d   = s2_vld_q;
        s3_vld_d   = s3_vld_q;
        if (abort) begin
            beat_cnt_d = '0;
            s1_vld_d   = 1'b0;
            s2_vld_d   = 1'b0;
            s3_vld_d   = 1'b0;
        end else if (!stall) begin
            if (accept) beat_cnt_d = (beat_cnt_q == LAST_CNT) ? '0 : beat_cnt_q + CNT_W'(1);
            s1_vld_d = accept;
            s2_vld_d = s1_vld_q;
            s3_vld_d = s2_vld_q;
        end
    end

    // ReLU, fraction drop (arithmetic shift floors toward -inf), then clip.
    always_comb begin
        relu_val = (s3_relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
        shifted  = relu_val >>> SHIFT;
        wide_val = SAT_W'(shifted);
        clipped  = sat_signed(wide_val, OUT_W);
    end

    assign load = s3_vld_q & s3_last_q & ~stall;

    always_comb begin
        out_value_d = out_value_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_value_d = OUT_W'(clipped);
            out_sat_d   = (clipped != wide_val);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            beat_cnt_q  <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            out_value_q <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s2_vld_q    <= s2_vld_d;
            s3_vld_q    <= s3_vld_d;
            out_value_q <= out_value_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath needs no reset: every consumer is qualified by a valid tag.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_prod_q      <= prod_d;
            s1_tag_q.first <= (beat_cnt_q == '0);
            s1_tag_q.last  <= (beat_cnt_q == LAST_CNT);
            s1_relu_q      <= relu_en;
            s1_bias_q      <= bias;

            s2_tag_q       <= s1_tag_q;
            s2_relu_q      <= s1_relu_q;
            s2_bias_q      <= s1_bias_q;
            s2_sum_q       <= ACC_W'(tree_sum);

            if (s2_vld_q) begin
                s3_last_q <= s2_tag_q.last;
                if (s2_tag_q.first) begin
                    acc_q     <= s2_bias_q + s2_sum_q;
                    s3_relu_q <= s2_relu_q;
                end else begin
                    acc_q     <= acc_q + s2_sum_q;
                end
            end
        end
    end

    assign out_value = out_value_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed vectors for dot_product_stream; expected results queued by the driver, checked by a monitor.
module tb_dot_product_stream;

    localparam int LANES = 28;
    localparam int BEATS = 28;
    localparam int PIX_W = 10;
    localparam int WGT_W = 19;
    localparam int OUT_W = 26;
    localparam int ACC_W = 39;

    logic                     clk = 1'b0;
    logic                     GlobalReset;
    logic [LANES*PIX_W-1:0]   in_pixels;
    logic [LANES*WGT_W-1:0]   in_weights;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ACC_W-1:0]  bias;
    logic                     relu_en;
    logic                     abort;
    logic signed [OUT_W-1:0]  out_value;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;

    typedef struct {
        logic [OUT_W-1:0] val;
        logic             sat;
        bit               chk_lat;
        int               exp_cyc;
        int               tid;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [OUT_W-1:0] mon_got;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               vec_done = 0;
    int               last_acc_cyc = 0;
    int               stalled = 0;
    int               base_done = 0;
    bit               seen = 0;

    dot_product_stream dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .in_pixels   (in_pixels),
        .in_weights  (in_weights),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bias        (bias),
        .relu_en     (relu_en),
        .abort       (abort),
        .out_value   (out_value),
        .out_sat     (out_sat),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!GlobalReset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("result with no expectation: queue depth", 64'(sb.size()), 64'd1);
            end else begin
                mon_e   = sb.pop_front();
                mon_got = out_value;
                check_eq($sformatf("t%0d out_value", mon_e.tid), 64'(mon_got), 64'(mon_e.val));
                check_eq($sformatf("t%0d out_sat", mon_e.tid), 64'(out_sat), 64'(mon_e.sat));
                if (mon_e.chk_lat)
                    check_eq($sformatf("t%0d result cycle", mon_e.tid), 64'(cyc), 64'(mon_e.exp_cyc));
            end
        end
    end

    // Presents one beat and holds it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat();
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check_eq("beat accept timeout", 64'(acc), 64'd1);
    endtask

    // Pixel = index%2 when alt, else pconst; bias/relu are only driven on the first beat.
    task automatic send_vector(input int tid, input bit alt, input logic [PIX_W-1:0] pconst,
                               input logic [WGT_W-1:0] wgt, input logic [ACC_W-1:0] b, input bit relu,
                               input int nbeats, input bit push, input logic [OUT_W-1:0] ev,
                               input bit es, input bit chk_lat);
        exp_t e;
        for (int bt = 0; bt < nbeats; bt++) begin
            for (int k = 0; k < LANES; k++) begin
                in_pixels[k*PIX_W +: PIX_W]  = alt ? PIX_W'((bt * LANES + k) % 2) : pconst;
                in_weights[k*WGT_W +: WGT_W] = wgt;
            end
            bias    = (bt == 0) ? b : '0;
            relu_en = (bt == 0) ? relu : 1'b0;
            send_beat();
        end
        if (push) begin
            e.val = ev; e.sat = es; e.chk_lat = chk_lat; e.exp_cyc = last_acc_cyc + 4; e.tid = tid;
            sb.push_back(e);
        end
        vec_done++;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        check_eq(name, 64'(sb.size()), 64'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        GlobalReset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        relu_en = 1'b0; bias = '0; in_pixels = '0; in_weights = '0;
        repeat (2) @(posedge clk);
        #3 GlobalReset = 1'b0;
        #1;
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset out_value", 64'(out_value), 64'd0);
        check_eq("reset out_sat", 64'(out_sat), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // 1/2: alternating pixels, unit weights, with and without bias
        send_vector(1, 1, '0, 19'h10000, '0, 0, BEATS, 1, 26'h1880000, 0, 1);
        drain("t1 drain");
        send_vector(2, 1, '0, 19'h10000, 39'h50000, 0, BEATS, 1, 26'h18D0000, 0, 1);
        drain("t2 drain");

        // 3: saturation both ways, ReLU
        send_vector(31, 0, 10'd1023, 19'h3FFFF, '0, 0, BEATS, 1, 26'h1FFFFFF, 1, 1);
        drain("t3a drain");
        send_vector(32, 0, 10'd1, 19'h70000, '0, 0, BEATS, 1, 26'h2000000, 1, 1);
        drain("t3b drain");
        send_vector(33, 0, 10'd1, 19'h70000, '0, 1, BEATS, 1, 26'h0000000, 0, 1);
        drain("t3c drain");

        // 4: back-to-back with a 6-cycle consumer stall around the first result
        base_done = vec_done;
        stalled = 0;
        seen = 0;
        fork
            begin
                send_vector(41, 1, '0, 19'h10000, '0, 0, BEATS, 1, 26'h1880000, 0, 0);
                send_vector(42, 0, 10'd1, 19'h10000, '0, 0, BEATS, 1, 26'h1FFFFFF, 1, 0);
            end
            begin
                for (int n = 0; n < 200 && !seen; n++) begin
                    @(posedge clk); #2;
                    if (vec_done > base_done) seen = 1;
                end
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) begin
                        stalled++;
                        check_eq("t4 in_ready while stalled", 64'(in_ready), 64'd0);
                    end
                end
                @(posedge clk); #1 out_ready = 1'b1;
                check_eq("t4 stalled cycles", 64'(stalled), 64'd4);
            end
        join
        drain("t4 drain");

        // 5: abort at beat 10, then a full vector
        send_vector(50, 1, '0, 19'h10000, '0, 0, 10, 0, '0, 0, 0);
        abort = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check_eq("t5 in_ready during abort", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        send_vector(5, 1, '0, 19'h10000, '0, 0, BEATS, 1, 26'h1880000, 0, 1);
        drain("t5 drain");
        repeat (20) @(posedge clk);
        #1;

        // 6: asynchronous reset over a held result, then over a partial vector
        out_ready = 1'b0;
        send_vector(60, 1, '0, 19'h10000, '0, 0, BEATS, 0, '0, 0, 0);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check_eq("t6 held out_valid", 64'(out_valid), 64'd1);
        check_eq("t6 held in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #2;
        GlobalReset = 1'b1;
        #1;
        check_eq("t6 async out_valid", 64'(out_valid), 64'd0);
        check_eq("t6 async out_value", 64'(out_value), 64'd0);
        check_eq("t6 async out_sat", 64'(out_sat), 64'd0);
        #1 GlobalReset = 1'b0;
        #2;
        check_eq("t6 in_ready after release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_vector(61, 0, 10'd1, 19'h10000, '0, 0, 10, 0, '0, 0, 0);
        #1 GlobalReset = 1'b1;
        #2 GlobalReset = 1'b0;
        @(posedge clk); #1;
        send_vector(6, 1, '0, 19'h10000, '0, 0, BEATS, 1, 26'h1880000, 0, 1);
        drain("t6 drain");
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
